// File: rtl/led_pwm_sequencer_if.sv
// Control/status bundle between the user/button logic (master) and led_pwm_sequencer (slave).
interface led_pwm_sequencer_if;
    logic       start;
    logic       stop;
    logic       repeat_mode;
    logic       pwm_enable;
    logic       pwm_reset_counter;
    logic       pwm_count_enable;
    logic       pwm_count_direction;
    logic       busy;
    logic       cycle_done;
    logic [2:0] state;

    modport master (
        output start, stop, repeat_mode,
        input  pwm_enable, pwm_reset_counter, pwm_count_enable, pwm_count_direction,
               busy, cycle_done, state
    );

    modport slave (
        input  start, stop, repeat_mode,
        output pwm_enable, pwm_reset_counter, pwm_count_enable, pwm_count_direction,
               busy, cycle_done, state
    );
endinterface

// File: rtl/led_pwm_sequencer.sv
// Breathing-cycle sequencer for one led_pwm: clear, ramp up, hold, ramp down, hold, repeat or stop.
// A shadow of the led_pwm duty counter keeps every step strictly inside 0..DUTY_CYCLE_MAXIMUM-1.
module led_pwm_sequencer #(
    parameter int unsigned DUTY_CYCLE_MAXIMUM = 200,
    parameter int unsigned TICK_DIVIDER       = 60000,
    parameter int unsigned HOLD_TICKS         = 50
) (
    input  logic               clk,
    input  logic               reset,
    led_pwm_sequencer_if.slave ctrl
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        RAMP_UP   = 3'd2,
        HOLD_HIGH = 3'd3,
        RAMP_DOWN = 3'd4,
        HOLD_LOW  = 3'd5
    } state_t;

    localparam logic [7:0]  SHADOW_TOP = 8'(DUTY_CYCLE_MAXIMUM - 1);
    localparam logic [23:0] TICK_LAST  = 24'(TICK_DIVIDER - 1);
    localparam logic [16:0] HOLD_LAST  = 17'(HOLD_TICKS);
    localparam bit          HOLD_NONE  = (HOLD_TICKS == 0);

    state_t      state_q, state_d;
    logic [23:0] prescaler_q;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        strobe_q, strobe_d;
    logic        done_q, done_d;
    logic        direction_q;
    logic        counting, tick, hold_exit;
    logic [16:0] hold_inc;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        shadow_d  = shadow_q;
        hold_d    = hold_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        counting  = (state_q == RAMP_UP) || (state_q == HOLD_HIGH) ||
                    (state_q == RAMP_DOWN) || (state_q == HOLD_LOW);
        tick      = counting && (prescaler_q == TICK_LAST);
        hold_inc  = {1'b0, hold_q} + 17'd1;
        hold_exit = HOLD_NONE || (tick && (hold_inc == HOLD_LAST));

        case (state_q)
            IDLE: begin
                if (ctrl.start) state_d = CLEAR;
            end
            CLEAR: begin
                shadow_d = '0;
                state_d  = RAMP_UP;
            end
            RAMP_UP: begin
                // Never step from the top value, so led_pwm never wraps upward.
                if (shadow_q >= SHADOW_TOP) begin
                    state_d = HOLD_HIGH;
                end else if (tick) begin
                    shadow_d = shadow_q + 8'd1;
                    strobe_d = 1'b1;
                    if (shadow_q + 8'd1 == SHADOW_TOP) state_d = HOLD_HIGH;
                end
            end
            HOLD_HIGH: begin
                if (hold_exit)  state_d = RAMP_DOWN;
                else if (tick)  hold_d  = hold_inc[15:0];
            end
            RAMP_DOWN: begin
                if (shadow_q == 8'd0) begin
                    state_d = HOLD_LOW;
                end else if (tick) begin
                    shadow_d = shadow_q - 8'd1;
                    strobe_d = 1'b1;
                    if (shadow_q == 8'd1) state_d = HOLD_LOW;
                end
            end
            HOLD_LOW: begin
                if (hold_exit) begin
                    done_d  = 1'b1;
                    state_d = ctrl.repeat_mode ? RAMP_UP : IDLE;
                end else if (tick) begin
                    hold_d = hold_inc[15:0];
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything; a strobe already computed this cycle is dropped.
        if (ctrl.stop) begin
            state_d  = IDLE;
            shadow_d = shadow_q;
            hold_d   = hold_q;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the values present before the edge.
        if (reset) begin
            state_q     <= IDLE;
            prescaler_q <= '0;
            hold_q      <= '0;
            shadow_q    <= '0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            direction_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            hold_q   <= (state_d != state_q) ? '0 : hold_d;

            if ((state_d != state_q) || !counting || tick) prescaler_q <= '0;
            else                                          prescaler_q <= prescaler_q + 24'd1;

            // Set from the upcoming state so direction is settled before the first strobe of a ramp.
            if (state_d == RAMP_UP)        direction_q <= 1'b1;
            else if (state_d == RAMP_DOWN) direction_q <= 1'b0;
        end
    end

    assign ctrl.pwm_enable          = (state_q != IDLE);
    assign ctrl.busy                = (state_q != IDLE);
    assign ctrl.pwm_reset_counter   = (state_q == CLEAR);
    assign ctrl.pwm_count_enable    = strobe_q;
    assign ctrl.pwm_count_direction = direction_q;
    assign ctrl.cycle_done          = done_q;
    assign ctrl.state               = state_q;
endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Bench: two sequencers (slow and fast configs) checked each cycle against a timeline model,
// with a led_pwm mirror per instance that flags any counter wrap.
module tb_led_pwm_sequencer;
    localparam int DCM  = 8;
    localparam int TD_A = 4;
    localparam int HT_A = 2;
    localparam int TD_B = 1;
    localparam int HT_B = 0;

    typedef struct {
        logic       rst;
        logic       st;
        logic       sp;
        logic [2:0] state_a;
        logic [2:0] state_b;
        logic       ce_a;
        logic       ce_b;
    } vec_t;

    logic clk         = 1'b0;
    logic reset       = 1'b1;
    logic start       = 1'b0;
    logic stop        = 1'b0;
    logic repeat_mode = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int td[2]      = '{TD_A, TD_B};
    int ht[2]      = '{HT_A, HT_B};
    int m_t[2]     = '{-1, -1};
    bit m_dir[2]   = '{1'b1, 1'b1};
    bit m_done[2]  = '{1'b0, 1'b0};
    int mir[2]     = '{0, 0};
    bit wrapped[2] = '{1'b0, 1'b0};

    vec_t vecs[8];

    always #5 clk = ~clk;

    led_pwm_sequencer_if bus_a ();
    led_pwm_sequencer_if bus_b ();

    assign bus_a.start       = start;
    assign bus_a.stop        = stop;
    assign bus_a.repeat_mode = repeat_mode;
    assign bus_b.start       = start;
    assign bus_b.stop        = stop;
    assign bus_b.repeat_mode = repeat_mode;

    led_pwm_sequencer #(.DUTY_CYCLE_MAXIMUM(DCM), .TICK_DIVIDER(TD_A), .HOLD_TICKS(HT_A))
        dut_a (.clk(clk), .reset(reset), .ctrl(bus_a));
    led_pwm_sequencer #(.DUTY_CYCLE_MAXIMUM(DCM), .TICK_DIVIDER(TD_B), .HOLD_TICKS(HT_B))
        dut_b (.clk(clk), .reset(reset), .ctrl(bus_b));

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // {state[2:0], enable, reset_counter, count_enable, direction, busy, cycle_done}
    function automatic logic [8:0] outs(input int c);
        if (c == 0)
            return {bus_a.state, bus_a.pwm_enable, bus_a.pwm_reset_counter, bus_a.pwm_count_enable,
                    bus_a.pwm_count_direction, bus_a.busy, bus_a.cycle_done};
        return {bus_b.state, bus_b.pwm_enable, bus_b.pwm_reset_counter, bus_b.pwm_count_enable,
                bus_b.pwm_count_direction, bus_b.busy, bus_b.cycle_done};
    endfunction

    // Expected outputs from the cycle offset t since CLEAR (t<0 means idle).
    function automatic logic [8:0] expect_outs(input int c);
        int t;
        int r;
        int hl;
        int p;
        logic [2:0] st;
        logic ce;
        t  = m_t[c];
        r  = (DCM - 1) * td[c];
        hl = (ht[c] == 0) ? 1 : ht[c] * td[c];
        p  = t - 1;
        if (t < 0)                 st = 3'd0;
        else if (t == 0)           st = 3'd1;
        else if (t <= r)           st = 3'd2;
        else if (t <= r + hl)      st = 3'd3;
        else if (t <= 2 * r + hl)  st = 3'd4;
        else                       st = 3'd5;
        ce = 1'b0;
        if (p >= 1 && p <= r && (p % td[c]) == 0) ce = 1'b1;
        if (p > r + hl && p <= 2 * r + hl && ((p - r - hl) % td[c]) == 0) ce = 1'b1;
        return {st, (t >= 0), (t == 0), ce, m_dir[c], (t >= 0), m_done[c]};
    endfunction

    task automatic model_edge(input int c);
        int r;
        int hl;
        int e;
        r  = (DCM - 1) * td[c];
        hl = (ht[c] == 0) ? 1 : ht[c] * td[c];
        e  = 2 * r + 2 * hl;
        m_done[c] = 1'b0;
        if (reset) begin
            m_t[c]   = -1;
            m_dir[c] = 1'b1;
        end else if (m_t[c] < 0) begin
            if (start && !stop) m_t[c] = 0;
        end else if (stop) begin
            m_t[c] = -1;
        end else if (m_t[c] == e) begin
            m_done[c] = 1'b1;
            m_t[c]    = repeat_mode ? 1 : -1;
        end else begin
            m_t[c]++;
        end
        if (m_t[c] == 1)          m_dir[c] = 1'b1;
        if (m_t[c] == r + hl + 1) m_dir[c] = 1'b0;
    endtask

    task automatic mirror_update(input int c);
        logic [8:0] o;
        o = outs(c);
        if (reset || o[4] === 1'b1) begin
            mir[c] = 0;
        end else if (o[5] === 1'b1 && o[3] === 1'b1) begin
            if (o[2]) begin
                if (mir[c] == DCM - 1) begin wrapped[c] = 1'b1; mir[c] = 0; end
                else mir[c]++;
            end else begin
                if (mir[c] == 0) begin wrapped[c] = 1'b1; mir[c] = DCM - 1; end
                else mir[c]--;
            end
        end
    endtask

    task automatic step();
        for (int c = 0; c < 2; c++) mirror_update(c);
        @(posedge clk);
        for (int c = 0; c < 2; c++) model_edge(c);
        #1;
        cyc++;
        check("cfg_a outputs", 32'(outs(0)), 32'(expect_outs(0)));
        check("cfg_b outputs", 32'(outs(1)), 32'(expect_outs(1)));
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int up_cnt, dn_cnt, peak, done_at, clears, strobes;
        int done_times[$];

        vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 3'd2, 3'd2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd2, 3'd2, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};

        // Reset held three cycles, then idle with no start.
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (50) step();
        check("idle state", 32'(bus_a.state), 32'd0);
        check("idle direction", 32'(bus_a.pwm_count_direction), 32'd1);
        check("idle busy", 32'(bus_a.busy), 32'd0);

        // Table: contention, start, strobe, stop suppressing a pending strobe, reset.
        for (int i = 0; i < 8; i++) begin
            reset = vecs[i].rst; start = vecs[i].st; stop = vecs[i].sp;
            step();
            check($sformatf("vec%0d state_a", i), 32'(bus_a.state), 32'(vecs[i].state_a));
            check($sformatf("vec%0d state_b", i), 32'(bus_b.state), 32'(vecs[i].state_b));
            check($sformatf("vec%0d strobe_a", i), 32'(bus_a.pwm_count_enable), 32'(vecs[i].ce_a));
            check($sformatf("vec%0d strobe_b", i), 32'(bus_b.pwm_count_enable), 32'(vecs[i].ce_b));
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0;

        // Single cycle; start pulsed again during RAMP_DOWN must not disturb it.
        do_reset();
        repeat_mode = 1'b0;
        start = 1'b1;
        step();
        check("single clear", 32'(bus_a.pwm_reset_counter), 32'd1);
        up_cnt = 0; dn_cnt = 0; peak = 0; done_at = -1;
        for (int n = 1; n <= 100; n++) begin
            start = (n >= 40 && n <= 44);
            step();
            if (mir[0] > peak) peak = mir[0];
            if (bus_a.pwm_count_enable) begin
                if (bus_a.pwm_count_direction) up_cnt++;
                else dn_cnt++;
            end
            if (bus_a.cycle_done) begin
                done_at = n;
                break;
            end
        end
        start = 1'b0;
        check("single up strobes", 32'(up_cnt), 32'd7);
        check("single down strobes", 32'(dn_cnt), 32'd7);
        check("single mirror peak", 32'(peak), 32'd7);
        check("single mirror end", 32'(mir[0]), 32'd0);
        check("single length", 32'(done_at), 32'd73);
        check("single ends idle", 32'(bus_a.state), 32'd0);

        // Repeat: three looping cycles, then drop repeat_mode.
        do_reset();
        repeat_mode = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        clears = 1;
        for (int n = 1; n <= 400; n++) begin
            step();
            if (bus_a.pwm_reset_counter) clears++;
            if (bus_a.cycle_done) begin
                done_times.push_back(n);
                if (done_times.size() == 3) repeat_mode = 1'b0;
                if (done_times.size() == 4) break;
            end
        end
        check("repeat done count", 32'(done_times.size()), 32'd4);
        if (done_times.size() == 4) begin
            check("repeat first done", 32'(done_times[0]), 32'd73);
            for (int k = 1; k < 4; k++)
                check($sformatf("repeat spacing %0d", k), 32'(done_times[k] - done_times[k-1]), 32'd72);
        end
        check("repeat single clear", 32'(clears), 32'd1);
        check("repeat ends idle", 32'(bus_a.state), 32'd0);

        // Stop on the cycle after the third up strobe.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        strobes = 0;
        for (int n = 0; n < 100 && strobes < 3; n++) begin
            step();
            if (bus_a.pwm_count_enable) strobes++;
        end
        check("stop third strobe seen", 32'(strobes), 32'd3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop state", 32'(bus_a.state), 32'd0);
        check("stop enable", 32'(bus_a.pwm_enable), 32'd0);
        check("stop mirror", 32'(mir[0]), 32'd3);
        repeat (10) step();
        check("stop mirror frozen", 32'(mir[0]), 32'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart clear", 32'(bus_a.state), 32'd1);
        step();
        check("restart mirror", 32'(mir[0]), 32'd0);

        // Fast config: consecutive strobes, then reset mid-RAMP_UP.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("fast strobe 1", 32'(bus_b.pwm_count_enable), 32'd1);
        step();
        check("fast strobe 2", 32'(bus_b.pwm_count_enable), 32'd1);
        check("fast in ramp", 32'(bus_b.state), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("fast reset outputs", 32'(outs(1)), 32'h004);

        // Random stimulus against the timeline model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 99) == 0) repeat_mode = ~repeat_mode;
            step();
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0;

        check("cfg_a no wrap", 32'(wrapped[0]), 32'd0);
        check("cfg_b no wrap", 32'(wrapped[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
